// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data_mem: each access runs IDLE -> ACCESS -> DONE.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; undefined gives fixed priority to port 0.
module dmem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_MemRead,
  output logic          mem_MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_w_data,
  input  logic [DW-1:0] mem_r_data,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]    req;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];

  assign req          = {m1_req, m0_req};
  assign req_we       = {m1_we, m0_we};
  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;

  logic [1:0]    state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          pick_valid;
  logic          pick;

  assign pick_valid = |req;

`ifdef DMEM_ARB_RR_EN
  // ptr_q holds the last granted port; a tie goes to the other one.
  logic ptr_q, ptr_d;

  always_comb begin
    pick = ~req[0];
    if (&req) begin
      pick = ~ptr_q;
    end
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pick_valid) begin
      ptr_d = pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick = ~req[0];
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          // Strobes and grant are set up one edge early so they are plain flop outputs in ACCESS.
          win_d       = pick;
          we_d        = req_we[pick];
          addr_d      = req_addr[pick];
          wdata_d     = req_wdata[pick];
          gnt_d[pick] = 1'b1;
          rd_d        = ~req_we[pick];
          wr_d        = req_we[pick];
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        done_d[win_q] = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Per-port read-data holding registers; a store leaves the previous load value in place.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (state_q == ST_ACCESS && !we_q && win_q == 1'(gi)) begin
          rdata_d = mem_r_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end
    end
  endgenerate

  assign m0_gnt       = gnt_q[0];
  assign m1_gnt       = gnt_q[1];
  assign m0_done      = done_q[0];
  assign m1_done      = done_q[1];
  assign m0_rdata     = g_port[0].rdata_q;
  assign m1_rdata     = g_port[1].rdata_q;
  assign mem_MemRead  = rd_q;
  assign mem_MemWrite = wr_q;
  assign mem_addr     = addr_q;
  assign mem_w_data   = wdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
